// File: rtl/praxos_wbm_pkg.sv
// Shared definitions for the Praxos Wishbone master: FSM states,
// Praxos port register map and STATUS bit positions.
package praxos_wbm_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_STROBE   = 2'd1,
      S_WAIT_ACK = 2'd2
   } state_t;

   localparam logic [4:0] PORT_ADDR   = 5'd0;
   localparam logic [4:0] PORT_WDATA  = 5'd1;
   localparam logic [4:0] PORT_CMD    = 5'd2;
   localparam logic [4:0] PORT_STATUS = 5'd3;
   localparam logic [4:0] PORT_RDATA  = 5'd4;

   localparam int unsigned ST_BUSY    = 0;
   localparam int unsigned ST_ACK     = 1;
   localparam int unsigned ST_ERR     = 2;
   localparam int unsigned ST_TIMEOUT = 3;
   localparam int unsigned ST_OVERRUN = 4;

endpackage

// File: rtl/praxos_wbm.sv
// Single-transaction Wishbone pipelined master controlled through the
// Praxos port bus; bounded by a timeout and reporting status/read data.
module praxos_wbm
   import praxos_wbm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  praxos_port_addr,
   input  logic        praxos_port_rd,
   input  logic        praxos_port_wr,
   input  logic [31:0] praxos_port_wr_data,
   output logic [31:0] praxos_port_rd_data,
   output logic [29:0] wbm_adr,
   output logic [31:0] wbm_dat_w,
   input  logic [31:0] wbm_dat_r,
   output logic [3:0]  wbm_sel,
   output logic        wbm_we,
   output logic        wbm_cyc,
   output logic        wbm_stb,
   input  logic        wbm_stall,
   input  logic        wbm_ack,
   input  logic        wbm_err,
   output logic        busy
);

   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

   state_t      r_state;
   state_t      w_state_next;
   logic [29:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [3:0]  r_sel;
   logic        r_we;
   logic        r_ack_done;
   logic        r_err;
   logic        r_timeout;
   logic        r_overrun;
   logic [15:0] r_cnt;

   logic [15:0] w_cnt_inc;
   logic        w_busy;
   logic        w_cmd_wr;
   logic        w_done_ack;
   logic        w_done_err;
   logic        w_tmo;
   logic [31:0] w_status;

   assign w_busy    = (r_state != S_IDLE);
   assign w_cmd_wr  = praxos_port_wr && (praxos_port_addr == PORT_CMD);
   assign w_cnt_inc = r_cnt + 16'd1;

   assign wbm_cyc   = w_busy;
   assign wbm_stb   = (r_state == S_STROBE);
   assign wbm_adr   = r_addr;
   assign wbm_dat_w = r_wdata;
   assign wbm_sel   = r_sel;
   assign wbm_we    = r_we;
   assign busy      = w_busy;

   // A response is only seen once the strobe is accepted (stall=0); it beats
   // the timeout when both land in the same cycle, and err beats ack.
   always_comb begin
      w_state_next = r_state;
      w_done_ack   = 1'b0;
      w_done_err   = 1'b0;
      w_tmo        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_wr) w_state_next = S_STROBE;
         end
         S_STROBE: begin
            if (!wbm_stall) begin
               w_done_err = wbm_err;
               w_done_ack = wbm_ack && !wbm_err;
            end
            if (w_done_ack || w_done_err) begin
               w_state_next = S_IDLE;
            end else if (w_cnt_inc == TMO_LIMIT) begin
               w_tmo        = 1'b1;
               w_state_next = S_IDLE;
            end else if (!wbm_stall) begin
               w_state_next = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            w_done_err = wbm_err;
            w_done_ack = wbm_ack && !wbm_err;
            if (w_done_ack || w_done_err) begin
               w_state_next = S_IDLE;
            end else if (w_cnt_inc == TMO_LIMIT) begin
               w_tmo        = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_sel      <= '0;
         r_we       <= 1'b0;
         r_ack_done <= 1'b0;
         r_err      <= 1'b0;
         r_timeout  <= 1'b0;
         r_overrun  <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_busy ? w_cnt_inc : '0;

         if (!w_busy && praxos_port_wr) begin
            case (praxos_port_addr)
               PORT_ADDR:  r_addr  <= praxos_port_wr_data[29:0];
               PORT_WDATA: r_wdata <= praxos_port_wr_data;
               PORT_CMD: begin
                  r_we       <= praxos_port_wr_data[0];
                  r_sel      <= praxos_port_wr_data[7:4];
                  r_ack_done <= 1'b0;
                  r_err      <= 1'b0;
                  r_timeout  <= 1'b0;
                  r_overrun  <= 1'b0;
               end
               default: ;
            endcase
         end else if (w_busy && w_cmd_wr) begin
            r_overrun <= 1'b1;
         end

         if (w_done_ack) begin
            r_ack_done <= 1'b1;
            if (!r_we) r_rdata <= wbm_dat_r;
         end
         if (w_done_err) r_err     <= 1'b1;
         if (w_tmo)      r_timeout <= 1'b1;
      end
   end

   always_comb begin
      w_status              = '0;
      w_status[ST_BUSY]     = w_busy;
      w_status[ST_ACK]      = r_ack_done;
      w_status[ST_ERR]      = r_err;
      w_status[ST_TIMEOUT]  = r_timeout;
      w_status[ST_OVERRUN]  = r_overrun;
      praxos_port_rd_data   = '0;
      if (praxos_port_rd) begin
         case (praxos_port_addr)
            PORT_ADDR:   praxos_port_rd_data = {2'b00, r_addr};
            PORT_WDATA:  praxos_port_rd_data = r_wdata;
            PORT_STATUS: praxos_port_rd_data = w_status;
            PORT_RDATA:  praxos_port_rd_data = r_rdata;
            default:     praxos_port_rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_praxos_wbm.sv
// Randomized bench for praxos_wbm: the bench plays the Wishbone slave and
// predicts each transaction's length and outcome from stall/response timing.
module tb_praxos_wbm;

   localparam int unsigned TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  praxos_port_addr;
   logic        praxos_port_rd;
   logic        praxos_port_wr;
   logic [31:0] praxos_port_wr_data;
   logic [31:0] praxos_port_rd_data;
   logic [29:0] wbm_adr;
   logic [31:0] wbm_dat_w;
   logic [31:0] wbm_dat_r;
   logic [3:0]  wbm_sel;
   logic        wbm_we;
   logic        wbm_cyc;
   logic        wbm_stb;
   logic        wbm_stall;
   logic        wbm_ack;
   logic        wbm_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [29:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   praxos_wbm #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .praxos_port_addr    (praxos_port_addr),
      .praxos_port_rd      (praxos_port_rd),
      .praxos_port_wr      (praxos_port_wr),
      .praxos_port_wr_data (praxos_port_wr_data),
      .praxos_port_rd_data (praxos_port_rd_data),
      .wbm_adr             (wbm_adr),
      .wbm_dat_w           (wbm_dat_w),
      .wbm_dat_r           (wbm_dat_r),
      .wbm_sel             (wbm_sel),
      .wbm_we              (wbm_we),
      .wbm_cyc             (wbm_cyc),
      .wbm_stb             (wbm_stb),
      .wbm_stall           (wbm_stall),
      .wbm_ack             (wbm_ack),
      .wbm_err             (wbm_err),
      .busy                (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Returns at the falling edge after the write edge, with the strobe cleared.
   task automatic port_wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      praxos_port_addr    = a;
      praxos_port_wr_data = d;
      praxos_port_wr      = 1'b1;
      @(negedge clk);
      praxos_port_wr      = 1'b0;
   endtask

   task automatic port_rd(input logic [4:0] a, output logic [31:0] d);
      praxos_port_addr = a;
      praxos_port_rd   = 1'b1;
      #1;
      d = praxos_port_rd_data;
      praxos_port_rd   = 1'b0;
      #1;
   endtask

   task automatic slave_idle();
      wbm_stall = 1'b0;
      wbm_ack   = 1'b0;
      wbm_err   = 1'b0;
      wbm_dat_r = $urandom;
   endtask

   // kind: 0 ack, 1 err, 2 ack+err, 3 no response.
   // ovr_mode: 0 none, 1 CMD write in cycle 1, 2 ADDR=0x55 in cycle 1 then CMD in cycle 2.
   task automatic run_txn(input logic [29:0] a, input logic [31:0] wd, input logic [7:0] cmd,
                          input int s, input int d, input int kind, input int ovr_mode,
                          input logic [31:0] rdat);
      int          r_cycle;
      int          exp_len;
      int          nbusy;
      bit          completes;
      bit          cmd_hit;
      logic [31:0] v;
      logic [31:0] exp_status;

      port_wr(5'd0, {2'b00, a});
      port_wr(5'd1, wd);
      m_addr  = a;
      m_wdata = wd;
      port_wr(5'd2, {24'h0, cmd});

      r_cycle   = s + 1 + d;
      completes = (kind != 3) && (r_cycle <= int'(TMO));
      exp_len   = completes ? r_cycle : int'(TMO);
      nbusy     = 0;
      cmd_hit   = 1'b0;

      for (int k = 1; k <= 40; k++) begin
         if (!wbm_cyc) break;
         nbusy++;
         chk("busy", 32'(busy), 32'd1);
         chk("stb", 32'(wbm_stb), 32'(k <= s + 1));
         if (wbm_stb) begin
            chk("adr", 32'(wbm_adr), {2'b00, m_addr});
            chk("dat_w", wbm_dat_w, m_wdata);
            chk("we", 32'(wbm_we), 32'(cmd[0]));
            chk("sel", 32'(wbm_sel), 32'(cmd[7:4]));
         end
         wbm_stall = (k <= s);
         wbm_ack   = (k <= s) ? 1'($urandom_range(0, 1)) : 1'b0;
         wbm_err   = 1'b0;
         wbm_dat_r = $urandom;
         if (k == r_cycle && kind != 3) begin
            wbm_ack   = (kind != 1);
            wbm_err   = (kind != 0);
            wbm_dat_r = rdat;
         end
         praxos_port_wr = 1'b0;
         if ((ovr_mode == 1 && k == 1) || (ovr_mode == 2 && k == 2)) begin
            praxos_port_addr    = 5'd2;
            praxos_port_wr_data = $urandom;
            praxos_port_wr      = 1'b1;
            cmd_hit             = 1'b1;
         end else if (ovr_mode == 2 && k == 1) begin
            praxos_port_addr    = 5'd0;
            praxos_port_wr_data = 32'h55;
            praxos_port_wr      = 1'b1;
         end
         @(negedge clk);
      end
      praxos_port_wr = 1'b0;
      slave_idle();

      chk("busy_cycles", 32'(nbusy), 32'(exp_len));
      chk("busy_after", 32'(busy), 32'd0);
      chk("stb_after", 32'(wbm_stb), 32'd0);

      if (completes && kind == 0 && !cmd[0]) m_rdata = rdat;
      exp_status = {27'd0, cmd_hit, 4'd0};
      if (!completes)     exp_status[3] = 1'b1;
      else if (kind == 0) exp_status[1] = 1'b1;
      else                exp_status[2] = 1'b1;

      port_rd(5'd3, v); chk("status", v, exp_status);
      port_rd(5'd4, v); chk("rdata", v, m_rdata);
      port_rd(5'd0, v); chk("addr_reg", v, {2'b00, m_addr});
      port_rd(5'd1, v); chk("wdata_reg", v, m_wdata);
   endtask

   initial begin
      logic [31:0] v;
      int          kind;

      rst_n               = 1'b0;
      praxos_port_addr    = '0;
      praxos_port_rd      = 1'b0;
      praxos_port_wr      = 1'b0;
      praxos_port_wr_data = '0;
      slave_idle();
      m_addr  = '0;
      m_wdata = '0;
      m_rdata = '0;
      repeat (3) @(negedge clk);

      chk("rst_cyc", 32'(wbm_cyc), 32'd0);
      chk("rst_stb", 32'(wbm_stb), 32'd0);
      chk("rst_we", 32'(wbm_we), 32'd0);
      chk("rst_sel", 32'(wbm_sel), 32'd0);
      chk("rst_adr", 32'(wbm_adr), 32'd0);
      chk("rst_dat_w", wbm_dat_w, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      port_rd(5'd3, v); chk("rst_status", v, 32'd0);
      port_rd(5'd4, v); chk("rst_rdata", v, 32'd0);
      praxos_port_addr = 5'd3;
      #1 chk("rd_idle_zero", praxos_port_rd_data, 32'd0);

      // directed cases
      run_txn(30'h100, 32'hDEADBEEF, 8'hF1, 0, 1, 0, 0, 32'h0);
      run_txn(30'h200, 32'h0, 8'hF0, 3, 2, 0, 0, 32'h12345678);
      run_txn(30'h300, 32'h0, 8'hF0, 0, 1, 1, 0, 32'hAAAA5555);
      run_txn(30'h400, 32'h0, 8'h30, 0, 0, 3, 0, 32'h0);
      run_txn(30'h404, 32'h0, 8'h10, 1, 0, 0, 0, 32'hCAFEF00D);
      run_txn(30'h500, 32'h11, 8'hF1, 0, 3, 0, 2, 32'h0);
      run_txn(30'h600, 32'h0, 8'hF0, 10, 0, 0, 0, 32'h0);
      run_txn(30'h700, 32'h0, 8'hF0, 2, 5, 0, 0, 32'h0BADBEEF);
      run_txn(30'h704, 32'h0, 8'hF0, 2, 6, 0, 0, 32'h0);
      run_txn(30'h708, 32'h0, 8'h50, 1, 1, 2, 1, 32'h0);
      port_rd(5'd5, v); chk("unmapped_rd", v, 32'd0);

      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 9);
         if (kind > 3) kind = 0;
         run_txn(30'($urandom), $urandom, 8'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                 kind, int'($urandom_range(0, 2)), $urandom);
      end

      // reset while waiting for ack
      port_wr(5'd0, 32'h77);
      port_wr(5'd2, 32'hF0);
      wbm_stall = 1'b0;
      @(negedge clk);
      chk("wait_ack_cyc", 32'(wbm_cyc), 32'd1);
      chk("wait_ack_stb", 32'(wbm_stb), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst2_cyc", 32'(wbm_cyc), 32'd0);
      chk("rst2_stb", 32'(wbm_stb), 32'd0);
      chk("rst2_busy", 32'(busy), 32'd0);
      port_rd(5'd3, v); chk("rst2_status", v, 32'd0);
      port_rd(5'd4, v); chk("rst2_rdata", v, 32'd0);
      port_rd(5'd0, v); chk("rst2_addr", v, 32'd0);
      m_addr  = '0;
      m_wdata = '0;
      m_rdata = '0;
      run_txn(30'h123, 32'h0, 8'hF0, 0, 1, 0, 0, 32'h87654321);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
